// File: rtl/omap_wr_biu.sv
// Output-feature-map write BIU: buffers merger results in a small FIFO and streams them
// to the memory arbiter as addressed write beats, signalling done once every response is back.
module omap_wr_biu #(
  parameter int DW          = 32,
  parameter int AW          = 32,
  parameter int DEPTH       = 4,
  parameter int ADDR_STRIDE = 1,
  parameter int CNT_W       = 24
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    out_ch,
  input  logic [15:0]   map_size,
  input  logic [AW-1:0] omap_base_addr,
  input  logic          conv_start,
  output logic          omap_biu2arb_req,
  output logic [AW-1:0] omap_biu2arb_addr,
  output logic [DW-1:0] omap_biu2arb_data,
  output logic          omap_biu2arb_vld,
  input  logic          omap_biu2arb_rdy,
  input  logic          arb2omap_biu_vld,
  output logic          arb2omap_biu_rdy,
  input  logic [DW-1:0] map_merger2omap_biu_data,
  input  logic          map_merger2omap_biu_vld,
  output logic          map_merger2omap_biu_rdy,
  output logic          omap_busy,
  output logic          omap_done
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_WAIT,
    S_DONE
  } state_e;

  state_e            state_q;
  logic              req_q;
  logic              busy_q;
  logic              done_q;

  logic [CNT_W-1:0]  total_q;
  logic [CNT_W-1:0]  in_cnt_q;
  logic [CNT_W-1:0]  out_cnt_q;
  logic [CNT_W-1:0]  rsp_cnt_q;
  logic [AW-1:0]     addr_q;

  logic [DW-1:0]     mem_q [DEPTH];
  logic [PW:0]       wr_ptr_q;
  logic [PW:0]       rd_ptr_q;

  logic              fifo_empty;
  logic              fifo_full;
  logic              in_rdy;
  logic              push;
  logic              pop;
  logic              start;
  logic              last_beat;
  logic              rsp_fire;
  logic [CNT_W-1:0]  start_total;

  assign start_total = CNT_W'(map_size) * CNT_W'(out_ch);
  assign start       = conv_start && (state_q == S_IDLE);

  // Extra pointer bit distinguishes full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                      (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  assign in_rdy    = (state_q == S_RUN) && !fifo_full && (in_cnt_q < total_q);
  assign push      = map_merger2omap_biu_vld && in_rdy;
  assign pop       = !fifo_empty && omap_biu2arb_rdy;
  assign last_beat = pop && (out_cnt_q == (total_q - CNT_W'(1)));
  assign rsp_fire  = arb2omap_biu_vld && ((state_q == S_RUN) || (state_q == S_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            busy_q <= 1'b1;
            if (start_total == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              req_q   <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (last_beat) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (rsp_cnt_q == total_q) begin
            state_q <= S_DONE;
            req_q   <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          req_q   <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      rsp_cnt_q <= '0;
      addr_q    <= '0;
    end else if (start) begin
      total_q   <= start_total;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      rsp_cnt_q <= '0;
      addr_q    <= omap_base_addr;
    end else begin
      if (push) begin
        in_cnt_q <= in_cnt_q + CNT_W'(1);
      end
      if (pop) begin
        out_cnt_q <= out_cnt_q + CNT_W'(1);
        addr_q    <= addr_q + AW'(ADDR_STRIDE);
      end
      if (rsp_fire) begin
        rsp_cnt_q <= rsp_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + (PW+1)'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + (PW+1)'(1);
      end
    end
  end

  // Storage needs no reset: the read port is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q[PW-1:0]] <= map_merger2omap_biu_data;
    end
  end

  assign omap_biu2arb_req        = req_q;
  assign omap_biu2arb_vld        = !fifo_empty;
  assign omap_biu2arb_addr       = addr_q;
  assign omap_biu2arb_data       = fifo_empty ? '0 : mem_q[rd_ptr_q[PW-1:0]];
  assign arb2omap_biu_rdy        = 1'b1;
  assign map_merger2omap_biu_rdy = in_rdy;
  assign omap_busy               = busy_q;
  assign omap_done               = done_q;

endmodule

// File: tb/tb_omap_wr_biu.sv
// Directed bench for omap_wr_biu: merger source, arbiter sink with 1-cycle responses,
// and a linear sequence of scenarios checked with immediate assertions.
module tb_omap_wr_biu;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  out_ch;
  logic [15:0] map_size;
  logic [31:0] base;
  logic        conv_start;
  logic        arb_req;
  logic [31:0] arb_addr;
  logic [31:0] arb_data;
  logic        arb_vld;
  logic        arb_rdy;
  logic        rsp_vld;
  logic        rsp_rdy;
  logic [31:0] m_data;
  logic        m_vld;
  logic        m_rdy;
  logic        busy;
  logic        done;

  int          n_vec = 0;
  int          n_err = 0;

  // Source/sink control shared between the directed sequence and the environment.
  int          m_limit = 0;
  int          m_sent  = 0;
  bit          m_rand  = 0;
  logic [31:0] m_seed  = '0;
  bit          a_hold  = 0;
  bit          a_rand  = 0;
  logic [31:0] exp_base = '0;
  int          beat_n  = 0;
  int          cyc     = 0;
  int          last_beat_cyc = 0;
  int          done_cyc = 0;

  always #5 clk = ~clk;

  omap_wr_biu #(
    .DW(32),
    .AW(32),
    .DEPTH(4),
    .ADDR_STRIDE(4),
    .CNT_W(24)
  ) dut (
    .clk                      (clk),
    .rst                      (rst),
    .out_ch                   (out_ch),
    .map_size                 (map_size),
    .omap_base_addr           (base),
    .conv_start               (conv_start),
    .omap_biu2arb_req         (arb_req),
    .omap_biu2arb_addr        (arb_addr),
    .omap_biu2arb_data        (arb_data),
    .omap_biu2arb_vld         (arb_vld),
    .omap_biu2arb_rdy         (arb_rdy),
    .arb2omap_biu_vld         (rsp_vld),
    .arb2omap_biu_rdy         (rsp_rdy),
    .map_merger2omap_biu_data (m_data),
    .map_merger2omap_biu_vld  (m_vld),
    .map_merger2omap_biu_rdy  (m_rdy),
    .omap_busy                (busy),
    .omap_done                (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Environment: handshakes sampled at negedge (stable), inputs updated 1ns after posedge.
  initial begin : env
    bit m_hs;
    bit a_hs;
    logic [31:0] ea;
    logic [31:0] ed;
    m_vld   = 1'b0;
    m_data  = '0;
    arb_rdy = 1'b1;
    rsp_vld = 1'b0;
    forever begin
      @(negedge clk);
      m_hs = m_vld && m_rdy;
      a_hs = arb_vld && arb_rdy;
      if (a_hs) begin
        ea = exp_base + 32'(beat_n) * 32'd4;
        ed = m_seed + 32'(beat_n);
        chk("beat_addr", arb_addr, ea);
        chk("beat_data", arb_data, ed);
        beat_n++;
      end
      if (m_hs) m_sent++;
      @(posedge clk);
      cyc++;
      if (a_hs) last_beat_cyc = cyc;
      #1;
      rsp_vld = a_hs;
      m_vld   = (m_sent < m_limit) && (!m_rand || ($urandom_range(0, 3) != 0));
      m_data  = m_seed + 32'(m_sent);
      arb_rdy = a_hold ? 1'b0 : (a_rand ? ($urandom_range(0, 1) == 1) : 1'b1);
    end
  end

  task automatic start_map(input logic [15:0] ms, input logic [7:0] oc, input logic [31:0] b,
                           input logic [31:0] seed, input int limit);
    @(posedge clk); #2;
    map_size   = ms;
    out_ch     = oc;
    base       = b;
    exp_base   = b;
    m_seed     = seed;
    m_sent     = 0;
    beat_n     = 0;
    m_limit    = limit;
    conv_start = 1'b1;
    @(posedge clk); #2;
    conv_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max_cyc);
    for (int i = 0; i < max_cyc; i++) begin
      @(posedge clk); #2;
      if (done === 1'b1) break;
    end
    done_cyc = cyc;
    chk(tag, done, 1'b1);
  endtask

  task automatic chk_idle_after_done(input string tag);
    @(posedge clk); #2;
    chk({tag, "_done_clr"}, done, 1'b0);
    chk({tag, "_busy_clr"}, busy, 1'b0);
    chk({tag, "_req_clr"}, arb_req, 1'b0);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, arb_req, 1'b0);
    chk({tag, "_vld"}, arb_vld, 1'b0);
    chk({tag, "_addr"}, arb_addr, 32'h0);
    chk({tag, "_data"}, arb_data, 32'h0);
    chk({tag, "_mrdy"}, m_rdy, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_rsprdy"}, rsp_rdy, 1'b1);
  endtask

  initial begin : main
    rst        = 1'b1;
    conv_start = 1'b0;
    map_size   = '0;
    out_ch     = '0;
    base       = '0;
    #1;
    chk_reset_vals("rst0");
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // 1: 8 words, full throughput, byte addressing from 0x1000
    start_map(16'd4, 8'd2, 32'h1000, 32'hA000_0000, 8);
    chk("t1_req", arb_req, 1'b1);
    chk("t1_busy", busy, 1'b1);
    chk("t1_vld_lat0", arb_vld, 1'b0);
    @(posedge clk); #2;
    chk("t1_vld_lat1", arb_vld, 1'b1);
    chk("t1_addr0", arb_addr, 32'h1000);
    chk("t1_data0", arb_data, 32'hA000_0000);
    wait_done("t1_done", 200);
    chk("t1_beats", beat_n, 8);
    chk("t1_done_lat", done_cyc - last_beat_cyc, 2);
    chk("t1_busy_done", busy, 1'b1);
    chk_idle_after_done("t1");

    // 2: arbiter stalled 10 cycles while merger streams
    a_hold = 1;
    start_map(16'd8, 8'd1, 32'h5000, 32'hB000_0000, 8);
    repeat (5) @(posedge clk);
    #2;
    chk("t2_addr_mid", arb_addr, 32'h5000);
    chk("t2_data_mid", arb_data, 32'hB000_0000);
    repeat (5) @(posedge clk);
    #2;
    chk("t2_accepted", m_sent, 4);
    chk("t2_mrdy_full", m_rdy, 1'b0);
    chk("t2_vld_held", arb_vld, 1'b1);
    chk("t2_addr_held", arb_addr, 32'h5000);
    chk("t2_data_held", arb_data, 32'hB000_0000);
    a_hold = 0;
    wait_done("t2_done", 200);
    chk("t2_beats", beat_n, 8);
    chk_idle_after_done("t2");

    // 3: empty map
    start_map(16'd0, 8'd5, 32'h7000, 32'h0, 0);
    chk("t3_done", done, 1'b1);
    chk("t3_busy", busy, 1'b1);
    chk("t3_req", arb_req, 1'b0);
    chk_idle_after_done("t3");
    chk("t3_beats", beat_n, 0);

    // 4: merger offers 12 words for an 8-word map
    start_map(16'd4, 8'd2, 32'h8000, 32'hC000_0000, 12);
    wait_done("t4_done", 200);
    chk("t4_accepted", m_sent, 8);
    chk("t4_beats", beat_n, 8);
    chk("t4_mrdy_extra", m_rdy, 1'b0);
    m_limit = 0;
    chk_idle_after_done("t4");

    // 5: reset after the third beat, then clean restart
    start_map(16'd4, 8'd2, 32'h2000, 32'hD000_0000, 8);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #2;
      if (beat_n >= 3) break;
    end
    chk("t5_beat3", beat_n >= 3, 1'b1);
    m_limit = 0;
    #1 rst = 1'b1;
    #1;
    chk_reset_vals("t5_rst");
    @(posedge clk); #2;
    rst = 1'b0;
    start_map(16'd4, 8'd2, 32'h3000, 32'hE000_0000, 8);
    wait_done("t5_done", 200);
    chk("t5_beats", beat_n, 8);
    chk_idle_after_done("t5");

    // 6: random stress over an address wrap, with an ignored start re-pulse
    m_rand = 1;
    a_rand = 1;
    start_map(16'd125, 8'd8, 32'hFFFF_FF00, 32'h1234_0000, 1000);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (beat_n >= 5) break;
    end
    map_size   = 16'd1;
    out_ch     = 8'd1;
    base       = 32'h0;
    conv_start = 1'b1;
    @(posedge clk); #2;
    conv_start = 1'b0;
    chk("t6_busy_restart", busy, 1'b1);
    chk("t6_req_restart", arb_req, 1'b1);
    wait_done("t6_done", 20000);
    chk("t6_beats", beat_n, 1000);
    chk("t6_accepted", m_sent, 1000);
    chk("t6_done_lat", done_cyc - last_beat_cyc, 2);
    chk_idle_after_done("t6");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
